// File: rtl/fetch_queue_if.sv
// Dequeue handshake between the fetch queue and the ID stage.
// master = fetch queue (producer), slave = ID (consumer).
interface fetch_queue_if;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc;

  modport master (
    output deq_valid,
    output deq_inst,
    output deq_pc,
    input  deq_ready
  );

  modport slave (
    input  deq_valid,
    input  deq_inst,
    input  deq_pc,
    output deq_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: credit-based IM fetch, PC-tagged FIFO, flush redirect.
// Optional perf counters built only when FETCHQ_PERF_EN is defined.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [31:0]            redirect_pc,
  output logic                   im_cs,
  output logic                   im_oe,
  output logic [13:0]            im_addr,
  input  logic [31:0]            im_data,
  fetch_queue_if.master          deq,
  output logic [$clog2(DEPTH):0] count,
  output logic [31:0]            perf_empty_cnt,
  output logic [31:0]            perf_flush_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   pend_pc;
  logic          pend;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];
  logic [CW:0]   credit;
  logic          wr;
  logic          rd;

  // In-flight request holds a reserved slot, so a response never overflows
  assign credit  = {1'b0, count} + {{CW{1'b0}}, pend};
  assign im_cs   = !rst && !flush && (credit < (CW+1)'(DEPTH));
  assign im_oe   = im_cs;
  assign im_addr = fetch_pc[15:2];

  assign wr = pend && !flush;
  assign rd = deq.deq_valid && deq.deq_ready;

  assign deq.deq_valid = (count != '0) && !flush;
  assign deq.deq_inst  = mem_inst[rd_ptr];
  assign deq.deq_pc    = mem_pc[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      pend_pc  <= '0;
      pend     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (flush) begin
      fetch_pc <= redirect_pc;
      pend     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (im_cs) begin
        pend_pc  <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      pend <= im_cs;
      if (wr) wr_ptr <= wr_ptr + PW'(1);
      if (rd) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(wr) - CW'(rd);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else if (wr) begin
      mem_inst[wr_ptr] <= im_data;
      mem_pc[wr_ptr]   <= pend_pc;
    end
  end

`ifdef FETCHQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_empty_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (deq.deq_ready && !deq.deq_valid && !flush &&
          perf_empty_cnt != 32'hFFFF_FFFF)
        perf_empty_cnt <= perf_empty_cnt + 32'd1;
      if (flush && perf_flush_cnt != 32'hFFFF_FFFF)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`else
  assign perf_empty_cnt = 32'h0;
  assign perf_flush_cnt = 32'h0;
`endif

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between the instruction SRAM and the ID stage. It owns the fetch PC and issues one word read per cycle to the instruction memory while credit is available. It captures each response, tagged with its PC, in a small FIFO and presents the oldest entry to ID through a valid/ready handshake. A branch/jump redirect (`flush`) discards all queued and in-flight fetches and restarts fetching at `redirect_pc`.

## Interface

Parameters:
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `RESET_PC`, 32'h0: fetch PC after reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `flush`  in  1  redirect request (EXE jump/branch taken).
- `redirect_pc`  in  32  new fetch PC; sampled when `flush`=1.
- `im_cs`  out  1  IM chip select; 1 in every cycle a read is issued.
- `im_oe`  out  1  IM output enable; equal to `im_cs`.
- `im_addr`  out  14  IM word address, `fetch_pc[15:2]`.
- `im_data`  in  32  IM read data; valid in the cycle after a request (fixed 1-cycle SRAM latency).
- `deq_ready`  in  1  ID accepts an instruction (ID not stalled).
- `deq_valid`  out  1  head entry is available.
- `deq_inst`  out  32  head instruction.
- `deq_pc`  out  32  PC of the head instruction.
- `count`  out  $clog2(DEPTH)+1  number of occupied entries.
- `perf_empty_cnt`  out  32  starved-cycle counter (see Configuration).
- `perf_flush_cnt`  out  32  flush counter (see Configuration).

## Operation

- State:
  - `fetch_pc` (32b).
  - `pend` (1b): a request was issued last cycle.
  - `pend_pc` (32b): PC of the in-flight request.
  - FIFO with `wr_ptr`/`rd_ptr` of `$clog2(DEPTH)` bits plus `count`.
- Issue rule: `im_cs = !flush && (count + pend < DEPTH)`.
  - On issue: `pend_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 4` (modulo 2^32), `pend <= 1`.
  - Otherwise: `pend <= 0`.
- Response capture: if `pend`=1 and `flush`=0, write {`im_data`, `pend_pc`} at `wr_ptr`, then advance `wr_ptr`.
- The credit rule guarantees a free slot for every response, so a write to a full queue cannot occur.
- Output: `deq_valid = (count != 0) && !flush`. `deq_inst`/`deq_pc` show the entry at `rd_ptr`.
- Dequeue: on `deq_valid && deq_ready`, advance `rd_ptr`.
- Simultaneous write and dequeue: `count` is unchanged and both pointers advance.
- Pointers wrap modulo `DEPTH`.
- Flush, with priority over everything else:
  - Next cycle: `count`=0, pointers equal, `pend`=0.
  - Any response arriving in the flush cycle is dropped.
  - `fetch_pc <= redirect_pc`, `im_cs`=0 in the flush cycle.
  - The first fetch at `redirect_pc` is issued in the following cycle.
- Reset values:
  - `fetch_pc`=`RESET_PC`, `pend`=0, pointers=0, `count`=0.
  - `deq_valid`=0, `im_cs`=`im_oe`=0 while `rst`=1.
  - `deq_inst`/`deq_pc` are 0.
  - Perf counters are 0.
- Reset asserted mid-operation discards all entries and any in-flight request immediately (asynchronous).

## Timing

- Fetch-to-ID latency: request in cycle N, `im_data` in N+1, enqueued at the end of N+1, `deq_valid` in N+2.
- Redirect: `flush` in cycle F, request for `redirect_pc` in F+1, `deq_valid` with that PC in F+3.
- Steady state with `deq_ready`=1 gives one instruction per cycle.
- When `deq_ready`=0, the queue fills to `DEPTH` and issue stops. With `DEPTH`=4, 4 entries are held and `im_cs`=0.
- After `rst` falls, the first request (`RESET_PC`) is issued in the first clock cycle.
- `deq_valid`, `deq_inst` and `deq_pc` are stable while `deq_ready`=0 and `flush`=0.

## Configuration

- `FETCHQ_PERF_EN` defined:
  - `perf_empty_cnt` increments each cycle with `deq_ready && !deq_valid && !flush`.
  - `perf_flush_cnt` increments each cycle with `flush`=1.
  - Both counters are 32-bit, saturate at 32'hFFFF_FFFF, and reset to 0.
- Not defined: both ports are tied to 32'h0 and no counter flops are built.

## Test plan

- Reset release with `RESET_PC`=0, IM word k = 32'h1000_0000+k, `deq_ready`=1 → `deq_valid` first high 2 cycles after the first request, with `deq_pc`=0 and `deq_inst`=32'h1000_0000. Then one instruction per cycle with PCs 4, 8, 12, …
- `deq_ready`=0 for 10 cycles from reset → `count` rises to 4 and `im_cs` falls to 0. After `deq_ready`=1, PCs 0,4,8,12,16 are dequeued in order with no gap or duplicate.
- `flush`=1 with `redirect_pc`=32'h0000_0100 while 3 entries are queued and one request is in flight:
  - next cycle `count`=0 and `deq_valid`=0;
  - `im_addr`=14'h040 one cycle later;
  - the next dequeued PC is 32'h100.
- `flush` on two consecutive cycles (0x200, then 0x300) → only PC 0x300 is fetched, and no entry from 0x200 ever appears.
- Async `rst` pulse mid-cycle while the queue is full → all outputs go to reset values immediately, and fetching restarts at `RESET_PC`.
- With `FETCHQ_PERF_EN`: hold `deq_ready`=1 through 3 flushes → `perf_flush_cnt`=3 and `perf_empty_cnt` counts the starved cycles (2 per flush plus 2 at reset). Without the macro, both ports read 0.
